// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/empty
// flags, registered read data, and sticky clearable overflow/underflow error flags.
module fifo_sync_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LVL);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // Handshake: a request is taken on the edge where it is asserted and accepted;
    // a write into a full FIFO is accepted only alongside a read, and a read is never
    // accepted while empty (no fall-through). Read data appears one cycle later,
    // qualified by data_valid.
    always_comb begin
        wr_acc = write_en & (~full | read_en);
        rd_acc = read_en & ~empty;
    end

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_C;
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + ONE_C;
                data_out <= mem[rd_ptr[ADDR_W-1:0]];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
            // A new error in the same cycle as err_clr wins over the clear.
            if (write_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (read_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (DATA_W=8, DEPTH=16, AF_LVL=12, AE_LVL=4).
module tb_fifo_sync_param;
    logic       clk;
    logic       reset;
    logic       write_en;
    logic [7:0] data_in;
    logic       read_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;

    fifo_sync_param #(
        .DATA_W(8), .DEPTH(16), .AF_LVL(12), .AE_LVL(4)
    ) dut (
        .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(data_out), .data_valid(data_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; write_en = 1'b0; read_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;

        // 1: reset
        step(); step();
        reset = 1'b1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);

        // 2: fill
        for (int i = 0; i < 16; i++) begin
            write_en = 1'b1; data_in = 8'(i);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af", 32'(almost_full), 32'((i + 1) >= 12));
            check("fill_full", 32'(full), 32'((i + 1) == 16));
            check("fill_empty", 32'(empty), 32'd0);
        end
        write_en = 1'b0;

        // 3: overflow at full, then clear
        write_en = 1'b1; data_in = 8'hAA;
        step();
        write_en = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // 2: drain in order, 0xAA must not appear
        for (int i = 0; i < 16; i++) begin
            read_en = 1'b1;
            step();
            check("drain_data", 32'(data_out), 32'(i));
            check("drain_dv", 32'(data_valid), 32'd1);
            check("drain_count", 32'(count), 32'(15 - i));
            check("drain_ae", 32'(almost_empty), 32'((15 - i) <= 4));
        end
        read_en = 1'b0;
        step();
        check("idle_dv", 32'(data_valid), 32'd0);
        check("idle_hold", 32'(data_out), 32'h0F);
        check("idle_empty", 32'(empty), 32'd1);

        // 4: underflow on empty read
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_dv", 32'(data_valid), 32'd0);
        check("unf_count", 32'(count), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("unf_clr", 32'(underflow), 32'd0);

        // 4: empty with simultaneous read/write; err_clr same cycle, set wins
        read_en = 1'b1; write_en = 1'b1; data_in = 8'h55; err_clr = 1'b1;
        step();
        write_en = 1'b0; err_clr = 1'b0;
        check("rw_empty_count", 32'(count), 32'd1);
        check("rw_empty_unf", 32'(underflow), 32'd1);
        check("rw_empty_dv", 32'(data_valid), 32'd0);
        step();
        read_en = 1'b0;
        check("rw_empty_data", 32'(data_out), 32'h55);
        check("rw_empty_dv2", 32'(data_valid), 32'd1);
        check("rw_empty_count2", 32'(count), 32'd0);

        // 5: preload 8, then 40 cycles of simultaneous read/write across wrap
        for (int i = 0; i < 8; i++) begin
            write_en = 1'b1; data_in = 8'(8'h10 + i);
            exp_q.push_back(data_in);
            step();
        end
        for (int i = 0; i < 40; i++) begin
            write_en = 1'b1; read_en = 1'b1; data_in = 8'(8'h80 + i);
            exp_q.push_back(data_in);
            step();
            exp_word = exp_q.pop_front();
            check("wrap_data", 32'(data_out), 32'(exp_word));
            check("wrap_count", 32'(count), 32'd8);
        end
        read_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            write_en = 1'b1; data_in = 8'(8'hC0 + $urandom_range(0, 63));
            exp_q.push_back(data_in);
            step();
        end
        check("full_again", 32'(full), 32'd1);

        // 5: simultaneous at full
        for (int i = 0; i < 20; i++) begin
            write_en = 1'b1; read_en = 1'b1; data_in = 8'(8'h20 + i);
            exp_q.push_back(data_in);
            step();
            exp_word = exp_q.pop_front();
            check("full_rw_data", 32'(data_out), 32'(exp_word));
            check("full_rw_count", 32'(count), 32'd16);
            check("full_rw_ovf", 32'(overflow), 32'd0);
        end
        write_en = 1'b0;

        // 6: drain to 5, then reset mid-stream
        for (int i = 0; i < 11; i++) begin
            read_en = 1'b1;
            step();
            exp_word = exp_q.pop_front();
            check("pre_rst_data", 32'(data_out), 32'(exp_word));
        end
        read_en = 1'b0;
        check("pre_rst_count", 32'(count), 32'd5);
        reset = 1'b0; write_en = 1'b1; data_in = 8'hEE;
        step();
        reset = 1'b1; write_en = 1'b0;
        exp_q.delete();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_dv", 32'(data_valid), 32'd0);
        check("mid_rst_dout", 32'(data_out), 32'd0);
        write_en = 1'b1; data_in = 8'hC3;
        step();
        write_en = 1'b0; read_en = 1'b1;
        step();
        read_en = 1'b0;
        check("post_rst_data", 32'(data_out), 32'hC3);
        check("post_rst_dv", 32'(data_valid), 32'd1);
        check("post_rst_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
